pb_op_sequencer: RTL and testbench

- Single-issue controller for the processing block.
- Accepts one ALU command at a time over a valid/ready handshake.
- Drives the register-file read addresses and the bf16 ALU control and reset, then waits for the ALU result valid.
- Writes the result back to the register file and reports completion to the issuing logic.

---
 rtl/pb_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_pb_op_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_op_sequencer.sv
// Single-issue sequencer: accepts one ALU command, drives the register-file reads and the
// bf16 ALU, then writes the result back. Define PB_SEQ_TIMEOUT_EN to add the EXEC watchdog.
module pb_op_sequencer #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              cmd_wb_en,
  output logic [ADDR_W-1:0] r1_addr,
  output logic [ADDR_W-1:0] r2_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write,
  output logic [3:0]        alu_ctrl,
  output logic              alu_reset,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_valid,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              error,
  output logic              busy,
  output logic [15:0]       op_count
);

`ifdef PB_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_EXEC, S_WB, S_ABORT} state_t;
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_EXEC, S_WB} state_t;
`endif

  state_t            state, state_nx;
  logic              rdy_en;   // low only in cycles following a reset edge
  logic [ADDR_W-1:0] rd_p0;
  logic              wb_en_p0;

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    write     = 1'b0;
    error     = 1'b0;
    alu_reset = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = rdy_en;
        alu_reset = ~rdy_en;
        if (cmd_valid && rdy_en) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        alu_reset = 1'b1;
        state_nx  = S_EXEC;
      end
      S_EXEC: begin
        if (alu_valid) state_nx = S_WB;
`ifdef PB_SEQ_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) state_nx = S_ABORT;
`endif
      end
      S_WB: begin
        done     = 1'b1;
        write    = wb_en_p0;
        state_nx = S_IDLE;
      end
`ifdef PB_SEQ_TIMEOUT_EN
      S_ABORT: begin
        done      = 1'b1;
        error     = 1'b1;
        alu_reset = 1'b1;
        state_nx  = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      rdy_en     <= 1'b0;
      r1_addr    <= '0;
      r2_addr    <= '0;
      write_addr <= '0;
      write_data <= '0;
      alu_ctrl   <= '0;
      result     <= '0;
      op_count   <= '0;
      rd_p0      <= '0;
      wb_en_p0   <= 1'b0;
`ifdef PB_SEQ_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      case (state)
        // p0: command capture at the accept edge
        S_IDLE: begin
          if (cmd_valid && rdy_en) begin
            r1_addr  <= cmd_rs1;
            r2_addr  <= cmd_rs2;
            alu_ctrl <= cmd_op;
            rd_p0    <= cmd_rd;
            wb_en_p0 <= cmd_wb_en;
          end
        end
        S_CLEAR: begin
`ifdef PB_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        // p1: ALU result capture
        S_EXEC: begin
          if (alu_valid) begin
            write_data <= alu_out;
            write_addr <= rd_p0;
            result     <= alu_out;
          end
`ifdef PB_SEQ_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_LAST) result <= '0;
          end
`endif
        end
        S_WB: op_count <= op_count + 16'd1;
`ifdef PB_SEQ_TIMEOUT_EN
        S_ABORT: op_count <= op_count + 16'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_op_sequencer.sv
// Directed bench for pb_op_sequencer: the bench plays register file and a bf16 adder ALU,
// with a queue of expected results popped at each completion.
module tb_pb_op_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic        cmd_wb_en = 1'b0;
  logic [15:0] r1_addr, r2_addr, write_addr, write_data;
  logic        write;
  logic [3:0]  alu_ctrl;
  logic        alu_reset;
  logic [15:0] alu_out = '0;
  logic        alu_valid = 1'b0;
  logic        done;
  logic [15:0] result;
  logic        error;
  logic        busy;
  logic [15:0] op_count;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic [15:0] rd;
    logic        wb;
  } cmd_t;

  int tests = 0, fails = 0, cyc = 0, wr_cnt = 0, exp_cnt = 0, acc_cyc = 0;
  logic [15:0] rf [16];
  logic [15:0] sb [$];

  pb_op_sequencer #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_wb_en(cmd_wb_en),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .write_addr(write_addr),
    .write_data(write_data), .write(write), .alu_ctrl(alu_ctrl),
    .alu_reset(alu_reset), .alu_out(alu_out), .alu_valid(alu_valid),
    .done(done), .result(result), .error(error), .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Positive normal bf16 add, truncating: enough for the operands used here.
  function automatic logic [15:0] bf16_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b;
    logic [7:0]  e;
    logic [9:0]  ma, mb, s;
    if (y[14:7] > x[14:7]) begin a = y; b = x; end
    else begin a = x; b = y; end
    e  = a[14:7];
    ma = {2'b01, a[6:0]};
    mb = {2'b01, b[6:0]} >> (a[14:7] - b[14:7]);
    s  = ma + mb;
    if (s[8]) begin s = s >> 1; e = e + 8'd1; end
    return {1'b0, e, s[6:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (write === 1'b1) begin
      rf[write_addr[3:0]] = write_data;
      wr_cnt++;
    end
  endtask

  task automatic drive(input cmd_t c);
    cmd_valid = 1'b1;
    cmd_op    = c.op;
    cmd_rs1   = c.rs1;
    cmd_rs2   = c.rs2;
    cmd_rd    = c.rd;
    cmd_wb_en = c.wb;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({p, "_write"}, 32'(write), 0);
    check({p, "_done"}, 32'(done), 0);
    check({p, "_error"}, 32'(error), 0);
    check({p, "_busy"}, 32'(busy), 0);
    check({p, "_alu_reset"}, 32'(alu_reset), 1);
    check({p, "_r1_addr"}, 32'(r1_addr), 0);
    check({p, "_r2_addr"}, 32'(r2_addr), 0);
    check({p, "_write_addr"}, 32'(write_addr), 0);
    check({p, "_write_data"}, 32'(write_data), 0);
    check({p, "_alu_ctrl"}, 32'(alu_ctrl), 0);
    check({p, "_result"}, 32'(result), 0);
    check({p, "_op_count"}, 32'(op_count), 0);
  endtask

  // Called at an IDLE negedge; returns at the IDLE negedge after completion.
  task automatic do_op(input string p, input cmd_t c, input int dly, input logic [15:0] want,
                       input logic stray, input logic hold, input cmd_t nxt);
    int lo, wr0;
    logic [15:0] got;
    lo  = 0;
    wr0 = wr_cnt;
    if (stray) begin
      alu_valid = 1'b1;
      alu_out   = 16'hDEAD;
      tick();
      alu_valid = 1'b0;
      check({p, "_stray_idle_busy"}, 32'(busy), 0);
      check({p, "_stray_idle_done"}, 32'(done), 0);
    end
    check({p, "_idle_ready"}, 32'(cmd_ready), 1);
    drive(c);
    sb.push_back(want);
    acc_cyc = cyc;
    tick();
    if (hold) drive(nxt);
    else cmd_valid = 1'b0;
    alu_valid = stray;
    alu_out   = stray ? 16'hBEEF : 16'h0000;
    if (!cmd_ready) lo++;
    check({p, "_clear_alu_reset"}, 32'(alu_reset), 1);
    check({p, "_clear_busy"}, 32'(busy), 1);
    check({p, "_clear_r1"}, 32'(r1_addr), 32'(c.rs1));
    check({p, "_clear_r2"}, 32'(r2_addr), 32'(c.rs2));
    check({p, "_clear_ctrl"}, 32'(alu_ctrl), 32'(c.op));
    tick();
    for (int i = 0; i <= dly; i++) begin
      check({p, "_exec_done"}, 32'(done), 0);
      check({p, "_exec_alu_reset"}, 32'(alu_reset), 0);
      check({p, "_exec_r1_hold"}, 32'(r1_addr), 32'(c.rs1));
      if (!cmd_ready) lo++;
      alu_valid = (i == dly);
      alu_out   = (i == dly) ? bf16_add(rf[r1_addr[3:0]], rf[r2_addr[3:0]]) : 16'h0000;
      tick();
    end
    alu_valid = 1'b0;
    alu_out   = 16'h0000;
    if (!cmd_ready) lo++;
    got = (sb.size() > 0) ? sb.pop_front() : 16'hXXXX;
    check({p, "_wb_done"}, 32'(done), 1);
    check({p, "_wb_error"}, 32'(error), 0);
    check({p, "_wb_write"}, 32'(write), 32'(c.wb));
    check({p, "_wb_result"}, 32'(result), 32'(got));
    check({p, "_wb_r1_hold"}, 32'(r1_addr), 32'(c.rs1));
    if (c.wb) begin
      check({p, "_wb_addr"}, 32'(write_addr), 32'(c.rd));
      check({p, "_wb_data"}, 32'(write_data), 32'(got));
    end
    tick();
    exp_cnt++;
    check({p, "_post_done"}, 32'(done), 0);
    check({p, "_post_ready"}, 32'(cmd_ready), 1);
    check({p, "_op_count"}, 32'(op_count), 32'(exp_cnt));
    check({p, "_ready_low_cycles"}, 32'(lo), 32'(dly + 3));
    check({p, "_write_count"}, 32'(wr_cnt - wr0), 32'(c.wb));
  endtask

  initial begin
    cmd_t a, b, z;
    int a_acc;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    rf[1] = 16'h3F80;
    rf[2] = 16'h4000;
    z = '0;

    // reset state
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b1;
    tick();
    check("release_ready", 32'(cmd_ready), 1);
    check("release_alu_reset", 32'(alu_reset), 0);

    // single op: 1.0 + 2.0 -> reg[3]
    a = '{op: 4'h1, rs1: 16'd1, rs2: 16'd2, rd: 16'd3, wb: 1'b1};
    do_op("single", a, 3, 16'h4040, 1'b0, 1'b0, z);
    check("single_rf3", 32'(rf[3]), 32'h4040);

    // back-to-back RAW: A writes reg[5], B reads it with cmd_valid held high
    a = '{op: 4'h1, rs1: 16'd1, rs2: 16'd2, rd: 16'd5, wb: 1'b1};
    b = '{op: 4'h1, rs1: 16'd5, rs2: 16'd1, rd: 16'd6, wb: 1'b1};
    do_op("raw_a", a, 0, 16'h4040, 1'b0, 1'b1, b);
    a_acc = acc_cyc;
    do_op("raw_b", b, 1, 16'h4080, 1'b0, 1'b0, z);
    check("raw_spacing", 32'(acc_cyc - a_acc), 4);
    check("raw_rf6", 32'(rf[6]), 32'h4080);

    // wb_en = 0: reported only
    a = '{op: 4'h1, rs1: 16'd3, rs2: 16'd3, rd: 16'd7, wb: 1'b0};
    do_op("nowb", a, 2, 16'h40C0, 1'b0, 1'b0, z);
    check("nowb_rf7", 32'(rf[7]), 0);

    // reset in EXEC together with alu_valid
    a = '{op: 4'h1, rs1: 16'd1, rs2: 16'd2, rd: 16'd8, wb: 1'b1};
    a_acc = wr_cnt;
    drive(a);
    tick();
    cmd_valid = 1'b0;
    tick();
    alu_valid = 1'b1;
    alu_out   = 16'h1234;
    reset     = 1'b0;
    tick();
    alu_valid = 1'b0;
    alu_out   = 16'h0000;
    check_reset_vals("midreset");
    check("midreset_no_write", 32'(wr_cnt - a_acc), 0);
    reset = 1'b1;
    tick();
    check("midreset_release_ready", 32'(cmd_ready), 1);
    check("midreset_rf8", 32'(rf[8]), 0);
    exp_cnt = 0;

    // stray alu_valid in IDLE and CLEAR
    a = '{op: 4'h3, rs1: 16'd2, rs2: 16'd2, rd: 16'd9, wb: 1'b1};
    do_op("stray", a, 1, 16'h4080, 1'b1, 1'b0, z);
    check("stray_rf9", 32'(rf[9]), 32'h4080);

`ifdef PB_SEQ_TIMEOUT_EN
    // watchdog abort after 8 EXEC cycles
    a = '{op: 4'h1, rs1: 16'd1, rs2: 16'd2, rd: 16'd10, wb: 1'b1};
    a_acc = wr_cnt;
    drive(a);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("tmo_exec_done", 32'(done), 0);
      tick();
    end
    check("tmo_done", 32'(done), 1);
    check("tmo_error", 32'(error), 1);
    check("tmo_result", 32'(result), 0);
    check("tmo_write", 32'(write), 0);
    check("tmo_alu_reset", 32'(alu_reset), 1);
    tick();
    exp_cnt++;
    check("tmo_post_ready", 32'(cmd_ready), 1);
    check("tmo_op_count", 32'(op_count), 32'(exp_cnt));
    check("tmo_no_write", 32'(wr_cnt - a_acc), 0);
`endif

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
